// File: rtl/stream_mux_nway_if.sv
// ---------------------------------------------------------------------------
// stream_mux_nway_if
//   Bundles the N input channels and the single output channel of the
//   stream_mux_nway block.
//
//   in_data   CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel word valid
//   in_ready  CHANNELS        per-channel accept, at most one bit high
//   sel       SEL_W           fixed channel select (fixed-select mode only)
//   out_data  WIDTH           registered output word
//   out_valid 1               out_data holds an undelivered word
//   out_ready 1               consumer accepts out_data this cycle
//   out_chan  SEL_W           channel that supplied out_data
//
//   master: producers/consumer side (the environment driving the mux)
//   slave : the mux itself
// ---------------------------------------------------------------------------
interface stream_mux_nway_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_chan;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_mux_nway.sv
// ---------------------------------------------------------------------------
// stream_mux_nway
//   N-way, W-bit stream multiplexer with valid/ready on every input channel
//   and one registered output stage. The channel is picked either by the
//   external sel input (MODE=0) or by a round-robin arbiter (MODE=1).
//   One word moves per accepted handshake, 1-cycle latency, full throughput.
//
// Ports
//   clk    in  clock, all state on the rising edge
//   reset  in  synchronous, active-high reset; drops any held word
//   bus    slave modport of stream_mux_nway_if (see that file for signals)
// ---------------------------------------------------------------------------
module stream_mux_nway #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                reset,
  stream_mux_nway_if.slave    bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    grant;
  logic                req;
  logic                load_en;
  logic                xfer;
  logic [CHANNELS-1:0] ready;
  logic [WIDTH-1:0]    grant_data;
  int                  scan_idx;

  // The stage can take a new word when it is empty or is being drained now.
  assign load_en = !bus.out_valid || bus.out_ready;

  // Grant selection. In round-robin mode the scan starts just after the last
  // channel served, so the previous winner has the lowest priority.
  always_comb begin
    grant    = '0;
    req      = 1'b0;
    scan_idx = 0;
    if (MODE == 0) begin
      grant = bus.sel;
      // sel values past the last channel (non power-of-two counts) request nothing
      if (int'(bus.sel) < CHANNELS)
        req = bus.in_valid[bus.sel];
    end else begin
      for (int off = 1; off <= CHANNELS; off++) begin
        scan_idx = (int'(rr_ptr) + off) % CHANNELS;
        if (!req && bus.in_valid[scan_idx]) begin
          req   = 1'b1;
          grant = SEL_W'(scan_idx);
        end
      end
    end
  end

  // One-hot ready towards the granted channel only; req already implies that
  // the granted channel is valid, so ready never goes to an idle channel.
  always_comb begin
    ready      = '0;
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        ready[i]   = load_en && req && !reset;
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.in_ready = ready;
  assign xfer         = |(bus.in_valid & ready);

  // Output register. A load takes priority over a drain so that back-to-back
  // words flow without a bubble; without a load a drain simply empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      rr_ptr        <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= grant_data;
      bus.out_chan  <= grant;
      if (MODE == 1)
        rr_ptr <= grant;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_nway.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_nway
//   Directed bench for stream_mux_nway. One instance runs in fixed-select
//   mode and is driven from a vector table; a second instance runs in
//   round-robin mode and is driven by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_stream_mux_nway;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stream_mux_nway_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) if0 ();
  stream_mux_nway_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) if1 ();

  stream_mux_nway #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  stream_mux_nway #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  // 10 ns clock; inputs change just after the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [1:0]  sel;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    if0.in_valid  = v.valid;
    if0.sel       = v.sel;
    if0.out_ready = v.ordy;
    #1;
  endtask

  // Check the round-robin instance: combinational ready and the output register
  task automatic checkRr(input string name, input logic [3:0] exp_ready,
                         input logic exp_valid, input logic [15:0] exp_data,
                         input logic [1:0] exp_chan);
    checkOutput({name, ".in_ready"}, 32'(if1.in_ready), 32'(exp_ready));
    checkOutput({name, ".out_valid"}, 32'(if1.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput({name, ".out_data"}, 32'(if1.out_data), 32'(exp_data));
      checkOutput({name, ".out_chan"}, 32'(if1.out_chan), 32'(exp_chan));
    end
  endtask

  task automatic driveRr(input logic [3:0] valid, input logic ordy);
    @(negedge clk);
    if1.in_valid  = valid;
    if1.out_ready = ordy;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Fixed-select table: each row checks ready before the edge and the
    // output register left behind by the previous row.
    vecs[0] = '{4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0};
    vecs[1] = '{4'b0100, 2'd1, 1'b1, 4'b0000, 1'b1, 16'hBEEF, 2'd2};
    vecs[2] = '{4'b0010, 2'd1, 1'b0, 4'b0010, 1'b0, 16'hBEEF, 2'd2};
    vecs[3] = '{4'b1111, 2'd3, 1'b0, 4'b0000, 1'b1, 16'h2222, 2'd1};
    vecs[4] = '{4'b1111, 2'd3, 1'b1, 4'b1000, 1'b1, 16'h2222, 2'd1};
    vecs[5] = '{4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1, 16'h4444, 2'd3};
    vecs[6] = '{4'b0000, 2'd0, 1'b1, 4'b0000, 1'b1, 16'h1111, 2'd0};
    vecs[7] = '{4'b1000, 2'd0, 1'b1, 4'b0000, 1'b0, 16'h1111, 2'd0};

    if0.in_data = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    if1.in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    // Reset with every channel requesting
    reset         = 1'b1;
    if0.in_valid  = 4'b1111;
    if0.sel       = 2'd0;
    if0.out_ready = 1'b0;
    if1.in_valid  = 4'b1111;
    if1.out_ready = 1'b0;
    if1.sel       = 2'd0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.in_ready0", 32'(if0.in_ready), 32'h0);
    checkOutput("rst.in_ready1", 32'(if1.in_ready), 32'h0);
    checkOutput("rst.out_valid", 32'(if1.out_valid), 32'h0);
    checkOutput("rst.out_data", 32'(if1.out_data), 32'h0);
    checkOutput("rst.out_chan", 32'(if1.out_chan), 32'h0);
    checkOutput("rst.out_valid0", 32'(if0.out_valid), 32'h0);

    // Round robin with all channels valid: 0,1,2,3,0,1 with no bubbles
    @(negedge clk);
    reset         = 1'b0;
    if0.in_valid  = 4'b0000;
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    #1;
    checkOutput("rr.first_grant", 32'(if1.in_ready), 32'h1);
    for (int n = 1; n < 6; n++) begin
      driveRr(4'b1111, 1'b1);
      checkRr($sformatf("rr.step%0d", n), 4'(1 << (n % 4)), 1'b1,
              16'(16'hA000 + (n - 1) % 4), 2'((n - 1) % 4));
    end

    // Back-pressure: word from ch1 held stable for three cycles
    for (int n = 0; n < 3; n++) begin
      driveRr(4'b1111, 1'b0);
      checkRr($sformatf("bp.stall%0d", n), 4'b0000, 1'b1, 16'hA001, 2'd1);
    end
    // Release with only ch3 valid: old word leaves, ch3 loads on the same edge
    driveRr(4'b1000, 1'b1);
    checkRr("bp.release", 4'b1000, 1'b1, 16'hA001, 2'd1);
    driveRr(4'b0000, 1'b1);
    checkRr("bp.loaded", 4'b0000, 1'b1, 16'hA003, 2'd3);

    // Skip/wrap with rr_ptr at 3 and only ch1, ch3 requesting
    driveRr(4'b1010, 1'b1);
    checkRr("wrap.g1", 4'b0010, 1'b0, 16'h0, 2'd0);
    driveRr(4'b1010, 1'b1);
    checkRr("wrap.g3", 4'b1000, 1'b1, 16'hA001, 2'd1);
    driveRr(4'b1010, 1'b1);
    checkRr("wrap.g1b", 4'b0010, 1'b1, 16'hA003, 2'd3);
    driveRr(4'b0000, 1'b0);
    checkRr("wrap.hold", 4'b0000, 1'b1, 16'hA001, 2'd1);

    // Fixed-select table on the MODE=0 instance
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("tbl%0d.in_ready", i), 32'(if0.in_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("tbl%0d.out_valid", i), 32'(if0.out_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("tbl%0d.out_data", i), 32'(if0.out_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("tbl%0d.out_chan", i), 32'(if0.out_chan), 32'(vecs[i].exp_chan));
    end

    // Mid-operation reset while the round-robin stage is stalled on a word
    driveRr(4'b0000, 1'b0);
    checkRr("mrst.before", 4'b0000, 1'b1, 16'hA001, 2'd1);
    @(negedge clk);
    reset = 1'b1;
    if1.in_valid = 4'b1111;
    #1;
    checkOutput("mrst.in_ready", 32'(if1.in_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    if1.in_valid = 4'b0000;
    #1;
    checkOutput("mrst.out_valid", 32'(if1.out_valid), 32'h0);
    checkOutput("mrst.out_data", 32'(if1.out_data), 32'h0);
    driveRr(4'b0000, 1'b1);
    checkOutput("mrst.dropped", 32'(if1.out_valid), 32'h0);
    driveRr(4'b1111, 1'b1);
    checkOutput("mrst.ptr_reset", 32'(if1.in_ready), 32'h1);
    driveRr(4'b0000, 1'b1);
    checkRr("mrst.first", 4'b0000, 1'b1, 16'hA000, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
